// File: rtl/lsu_align_if.sv
// Request/response and word-memory bus of the load/store alignment unit.
// slave is the alignment unit; master is the EX stage plus the data memory.
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: sub-word load extraction/extension, read-modify-write
// for byte/halfword stores, and rejection of misaligned/out-of-range/illegal requests.
module lsu_align #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_align_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] merge_p1;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_bad;
  logic        busy_mem;

  function automatic logic req_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a);
    logic bad_f3;
    bad_f3 = we ? (f3[2] | (f3[1:0] == 2'b11))
                : ((f3[1:0] == 2'b11) | (f3 == 3'b110));
    return bad_f3 | ((f3[1:0] == 2'b01) & a[0])
                  | ((f3[1:0] == 2'b10) & (a[1:0] != 2'b00))
                  | (a >= 32'(ADDR_LIMIT));
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'h0, b} : 32'(b);
      2'b01:   r = f3[2] ? {16'h0, h} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_word(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (f3[1:0] == 2'b00)
      r[8*off +: 8] = wd[7:0];
    else if (off[1])
      r[31:16] = wd[15:0];
    else
      r[15:0] = wd[15:0];
    return r;
  endfunction

  assign accept  = bus.req_valid & (state == IDLE);
  assign req_bad = req_err(bus.req_we, bus.req_funct3, bus.req_addr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad)                       state_nxt = RESP;
          else if (!bus.req_we)              state_nxt = LOAD;
          else if (bus.req_funct3[1:0] == 2'b10) state_nxt = WRITE;
          else                               state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory side is decoded purely from state so reset drops it without a clock
  assign busy_mem      = (state == LOAD) | (state == RMW_RD) | (state == WRITE);
  assign bus.req_ready = (state == IDLE);
  assign bus.mem_read  = (state == LOAD) | (state == RMW_RD);
  assign bus.mem_write = (state == WRITE);
  assign bus.mem_addr  = busy_mem ? {addr_p0[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata = (state != WRITE) ? 32'h0
                       : (funct3_p0[1:0] == 2'b10) ? wdata_p0 : merge_p1;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_p0     <= 1'b0;
      funct3_p0 <= 3'b0;
      addr_p0   <= 32'h0;
      wdata_p0  <= 32'h0;
      merge_p1  <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_p0     <= bus.req_we;
        funct3_p0 <= bus.req_funct3;
        addr_p0   <= bus.req_addr;
        wdata_p0  <= bus.req_wdata;
        if (req_bad) begin
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end
      end
      // Response fields only change on the edge that enters RESP
      if (state == LOAD) begin
        err_q   <= 1'b0;
        rdata_q <= load_ext(funct3_p0, addr_p0[1:0], bus.mem_rdata);
      end
      if (state == RMW_RD)
        merge_p1 <= merge_word(funct3_p0, addr_p0[1:0], bus.mem_rdata, wdata_p0);
      if (state == WRITE && we_p0) begin
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Randomized bench for lsu_align against a byte-level memory reference model,
// with directed load/store/error/reset/back-to-back scenarios.
module tb_lsu_align;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_align_if bus ();
  lsu_align #(.ADDR_LIMIT(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem  [256];
  logic [31:0] refm [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  int          rd_total = 0;
  int          wr_total = 0;
  int          both_total = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:2]] : 32'hDEAD_DEAD;

  always @(posedge clk) begin
    if (bus.mem_write)   mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    else if (pl_en)      mem[pl_addr] <= pl_data;
    if (bus.mem_read)    rd_total <= rd_total + 1;
    if (bus.mem_write)   wr_total <= wr_total + 1;
    if (bus.mem_read && bus.mem_write) both_total <= both_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] widx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = widx; pl_data = data;
    refm[widx] = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Reference: decide legality from sizes, then act on whole bytes of the word.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic e, output logic [31:0] rd,
                           output int lat, output int nrd, output int nwr);
    int          size, off;
    bit          legal;
    logic [31:0] w, mask;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    e     = !legal || (addr % size) != 0 || addr >= 32'd1024;
    rd = 32'h0; nrd = 0; nwr = 0; lat = 1;
    if (!e) begin
      w    = refm[addr[9:2]];
      off  = int'(addr % 4);
      mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (!we) begin
        rd = (w >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | ~mask;
        lat = 2; nrd = 1;
      end else begin
        for (int b = 0; b < size; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
        refm[addr[9:2]] = w;
        lat = (size == 4) ? 2 : 3;
        nrd = (size < 4) ? 1 : 0;
        nwr = 1;
      end
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got);
    logic        e;
    logic [31:0] rd;
    int          lat, nrd, nwr, r0, w0, cyc;
    model_req(we, f3, addr, wd, e, rd, lat, nrd, nwr);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    r0 = rd_total; w0 = wr_total;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    got = bus.rsp_rdata;
    chk({tag, "_lat"},   32'(cyc), 32'(lat));
    chk({tag, "_err"},   32'(bus.rsp_err), 32'(e));
    chk({tag, "_rdata"}, bus.rsp_rdata, rd);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_nrd"},   32'(rd_total - r0), 32'(nrd));
    chk({tag, "_nwr"},   32'(wr_total - w0), 32'(nwr));
    chk({tag, "_mem"},   mem[addr[9:2]], refm[addr[9:2]]);
  endtask

  logic [31:0] got;
  logic        q_err [$];
  logic [31:0] q_rd  [$];

  initial begin
    logic        e, we;
    logic [2:0]  f3;
    logic [31:0] rd, addr, wd;
    int          lat, nrd, nwr, w0, k, resp, cyc, last_acc, prev_gap;
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = 8'h0; pl_data = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_rspv",   32'(bus.rsp_valid), 32'd0);
    chk("rst_rspe",   32'(bus.rsp_err), 32'd0);
    chk("rst_rdata",  bus.rsp_rdata, 32'h0);
    chk("rst_mrd",    32'(bus.mem_read), 32'd0);
    chk("rst_mwr",    32'(bus.mem_write), 32'd0);
    chk("rst_maddr",  bus.mem_addr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    preload(8'h04, 32'h80FF7F01);
    preload(8'h08, 32'h11223344);

    do_req("lb11", 1'b0, 3'b000, 32'h11, 32'h0, got);  chk("lb11_val", got, 32'h0000007F);
    do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, got);  chk("lb13_val", got, 32'hFFFFFF80);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, got); chk("lbu13_val", got, 32'h00000080);
    do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, got);  chk("lh12_val", got, 32'hFFFF80FF);
    do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, got); chk("lhu12_val", got, 32'h000080FF);
    do_req("sb22", 1'b1, 3'b000, 32'h22, 32'hAB, got); chk("sb22_mem", mem[8], 32'h11AB3344);
    do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, got);  chk("lw20_val", got, 32'h11AB3344);
    do_req("sh20", 1'b1, 3'b001, 32'h20, 32'hBEEF, got); chk("sh20_mem", mem[8], 32'h11ABBEEF);
    do_req("sw40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, got);
    do_req("lw40", 1'b0, 3'b010, 32'h40, 32'h0, got);  chk("lw40_val", got, 32'hDEADBEEF);
    do_req("e_lh21",  1'b0, 3'b001, 32'h21,  32'h0, got);
    do_req("e_lw22",  1'b0, 3'b010, 32'h22,  32'h0, got);
    do_req("e_sw400", 1'b1, 3'b010, 32'h400, 32'h5, got);
    do_req("e_ld011", 1'b0, 3'b011, 32'h10,  32'h0, got);
    do_req("e_st100", 1'b1, 3'b100, 32'h10,  32'h0, got);

    // Reset during the read half of a byte store
    w0 = wr_total;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h24; bus.req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rmw_mrd_before", 32'(bus.mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmw_mrd_async", 32'(bus.mem_read), 32'd0);
    chk("rmw_mwr_async", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmw_ready", 32'(bus.req_ready), 32'd1);
    chk("rmw_rspv",  32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rmw_rspv2", 32'(bus.rsp_valid), 32'd0);
    chk("rmw_nwr",   32'(wr_total - w0), 32'd0);
    chk("rmw_mem",   mem[9], refm[9]);

    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 9) == 0) ? $urandom_range(1000, 1100) : $urandom_range(0, 127);
      do_req("rand", we, f3, addr, $urandom, got);
    end

    // Back-to-back with req_valid held high: alternating LW / SB
    k = 0; resp = 0; cyc = 0; last_acc = 0; prev_gap = 0;
    while (resp < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) begin
        if (q_err.size() == 0) chk("b2b_extra_rsp", 32'd1, 32'd0);
        else begin
          chk("b2b_err",   32'(bus.rsp_err), 32'(q_err.pop_front()));
          chk("b2b_rdata", bus.rsp_rdata, q_rd.pop_front());
        end
        resp++;
      end
      if (k < 12) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = k[0];
        bus.req_funct3 = k[0] ? 3'b000 : 3'b010;
        bus.req_addr   = k[0] ? 32'(32'h60 + k) : 32'h60;
        bus.req_wdata  = 32'(k * 17 + 3);
      end else bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        if (k > 0) chk("b2b_gap", 32'(cyc - last_acc), 32'(prev_gap));
        model_req(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata, e, rd, lat, nrd, nwr);
        q_err.push_back(e);
        q_rd.push_back(rd);
        prev_gap = lat + 1;
        last_acc = cyc;
        k++;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd12);
    chk("b2b_resps",   32'(resp), 32'd12);
    @(negedge clk);
    chk("b2b_mem", mem[24], refm[24]);
    chk("rd_wr_overlap", 32'(both_total), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
